// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS sequencing controller:
// state encodings, supported opcodes, and the ALU-op, ALU-B-select
// and PC-select codes that the controller drives onto the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ORIEX  = 4'd10,
    ST_IMMWB  = 4'd11,
    ST_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle controller and the datapath.
// master: controller side (takes opcode/zero/mem_ready, drives controls).
// slave : datapath side (drives opcode/zero/mem_ready, takes controls).
interface multicycle_control_fsm_if #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned STATE_W  = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_en;
  logic [1:0]          pc_src;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                ext_zero;
  logic                instr_done;
  logic                illegal_op;
  logic [STATE_W-1:0]  state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, ext_zero,
           instr_done, illegal_op, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, ext_zero,
           instr_done, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multicycle MIPS core. Shares one ALU and
// one unified memory across several cycles per instruction; memory
// states wait on mem_ready.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - control bundle (master modport): opcode/zero/mem_ready in,
//           datapath controls, instr_done, illegal_op, state_dbg out
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned STATE_W  = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_q_d;
  logic                op_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_q_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_q_d   = op_q;
    op_legal = 1'b1;
    case (state_q)
      ST_FETCH:  if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        op_q_d = bus.opcode;
        case (bus.opcode)
          OPCODE_W'(OP_RTYPE):            state_d = ST_EXEC;
          OPCODE_W'(OP_LW),
          OPCODE_W'(OP_SW):               state_d = ST_MEMADR;
          OPCODE_W'(OP_BEQ):              state_d = ST_BRANCH;
          OPCODE_W'(OP_ADDI):             state_d = ST_ADDIEX;
          OPCODE_W'(OP_ORI):              state_d = ST_ORIEX;
          OPCODE_W'(OP_J):                state_d = ST_JUMP;
          default: begin
            op_legal = 1'b0;
            state_d  = ST_FETCH;
          end
        endcase
      end
      // The IR may change after DECODE, so lw/sw is resolved from op_q.
      ST_MEMADR: state_d = (op_q == OPCODE_W'(OP_LW)) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (bus.mem_ready) state_d = ST_MEMWB;
      ST_MEMWR:  if (bus.mem_ready) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ADDIEX,
      ST_ORIEX:  state_d = ST_IMMWB;
      ST_MEMWB,
      ST_ALUWB,
      ST_BRANCH,
      ST_IMMWB,
      ST_JUMP:   state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    bus.pc_en      = 1'b0;
    bus.pc_src     = PCSRC_ALU;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = ALUSRCB_REG;
    bus.alu_op     = ALUOP_ADD;
    bus.ext_zero   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;
    bus.state_dbg  = STATE_W'(state_q);
    // Reset gating: FETCH is the reset state but must not issue a read
    // (or any other control) while rst_n is held low.
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = ALUSRCB_FOUR;
          bus.ir_write  = bus.mem_ready;
          bus.pc_en     = bus.mem_ready;
        end
        ST_DECODE: begin
          bus.alu_src_b  = ALUSRCB_BROFF;
          bus.illegal_op = !op_legal;
          bus.instr_done = !op_legal;
        end
        ST_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = ALUSRCB_IMM;
        end
        ST_MEMRD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        ST_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
        end
        ST_MEMWR: begin
          bus.mem_write  = 1'b1;
          bus.iord       = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        ST_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALUOP_FUNCT;
        end
        ST_ALUWB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 1'b1;
          bus.instr_done = 1'b1;
        end
        ST_BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_op     = ALUOP_SUB;
          bus.pc_src     = PCSRC_ALUOUT;
          bus.pc_en      = bus.zero;
          bus.instr_done = 1'b1;
        end
        ST_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = ALUSRCB_IMM;
        end
        ST_ORIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = ALUSRCB_IMM;
          bus.alu_op    = ALUOP_OR;
          bus.ext_zero  = 1'b1;
        end
        ST_IMMWB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        ST_JUMP: begin
          bus.pc_src     = PCSRC_JUMP;
          bus.pc_en      = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  typedef struct {
    logic [5:0] op;
    logic       mr;
    logic       z;
    logic       ill;
    state_e     st;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [21:0] sb[$];

  multicycle_control_fsm_if #(.OPCODE_W(6), .STATE_W(4)) bus();

  multicycle_control_fsm #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [21:0] obs;
  assign obs = {bus.state_dbg, bus.pc_en, bus.pc_src, bus.iord, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.ext_zero, bus.instr_done, bus.illegal_op};

  // Expected control word per state, straight from the state table.
  function automatic logic [21:0] exp_vec(state_e st, logic mr, logic z, logic ill);
    logic pe = 0, io = 0, rd = 0, wr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0;
    logic sa = 0, ez = 0, dn = 0, il = 0;
    logic [1:0] ps = 2'b00, sb_ = 2'b00, ao = 2'b00;
    case (st)
      ST_FETCH:  begin rd = 1; sb_ = 2'b01; irw = mr; pe = mr; end
      ST_DECODE: begin sb_ = 2'b11; il = ill; dn = ill; end
      ST_MEMADR: begin sa = 1; sb_ = 2'b10; end
      ST_MEMRD:  begin rd = 1; io = 1; end
      ST_MEMWB:  begin rw = 1; m2r = 1; dn = 1; end
      ST_MEMWR:  begin wr = 1; io = 1; dn = mr; end
      ST_EXEC:   begin sa = 1; ao = 2'b10; end
      ST_ALUWB:  begin rw = 1; rdst = 1; dn = 1; end
      ST_BRANCH: begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; dn = 1; end
      ST_ADDIEX: begin sa = 1; sb_ = 2'b10; end
      ST_ORIEX:  begin sa = 1; sb_ = 2'b10; ao = 2'b11; ez = 1; end
      ST_IMMWB:  begin rw = 1; dn = 1; end
      ST_JUMP:   begin ps = 2'b10; pe = 1; dn = 1; end
      default: ;
    endcase
    return {st, pe, ps, io, rd, wr, irw, rdst, m2r, rw, sa, sb_, ao, ez, dn, il};
  endfunction

  function automatic step_t S(logic [5:0] op, logic mr, logic z, logic ill, state_e st);
    step_t s;
    s.op = op; s.mr = mr; s.z = z; s.ill = ill; s.st = st;
    return s;
  endfunction

  // Drive one cycle of stimulus and queue the control word it should produce.
  task automatic apply(input step_t s);
    @(posedge clk); #1;
    bus.opcode    = s.op;
    bus.mem_ready = s.mr;
    bus.zero      = s.z;
    sb.push_back(exp_vec(s.st, s.mr, s.z, s.ill));
  endtask

  task automatic test_reset();
    step_t seq[$];
    logic [21:0] e;
    rst_n = 1'b0; bus.opcode = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin $display("FAIL reset_hold got=%h exp=%h", obs, 22'h0); failures++; end
    rst_n = 1'b1;
    apply(S(OP_J, 1'b0, 1'b0, 1'b0, ST_FETCH));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin $display("FAIL reset_fetch_stall got=%h exp=%h", obs, e); failures++; end
    #2 rst_n = 1'b0;
    #1 checks++;
    if (obs !== '0) begin $display("FAIL reset_mid_fetch got=%h exp=%h", obs, 22'h0); failures++; end
    @(negedge clk) rst_n = 1'b1;
    seq.push_back(S(OP_J, 1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_J, 1'b1, 1'b0, 1'b0, ST_DECODE));
    seq.push_back(S(OP_J, 1'b1, 1'b0, 1'b0, ST_JUMP));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin $display("FAIL reset_release[%0d] got=%h exp=%h", i, obs, e); failures++; end
    end
  endtask

  task automatic test_rtype();
    step_t seq[$];
    logic [21:0] e;
    seq.push_back(S(OP_RTYPE, 1'b0, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_RTYPE, 1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_RTYPE, 1'b1, 1'b0, 1'b0, ST_DECODE));
    seq.push_back(S(OP_RTYPE, 1'b1, 1'b0, 1'b0, ST_EXEC));
    seq.push_back(S(OP_RTYPE, 1'b1, 1'b0, 1'b0, ST_ALUWB));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin $display("FAIL rtype[%0d] got=%h exp=%h", i, obs, e); failures++; end
    end
  endtask

  task automatic test_lw_stall();
    step_t seq[$];
    logic [21:0] e;
    seq.push_back(S(OP_LW, 1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_LW, 1'b1, 1'b0, 1'b0, ST_DECODE));
    // IR contents changed after decode: the lw/sw choice must still be lw.
    seq.push_back(S(OP_SW, 1'b1, 1'b0, 1'b0, ST_MEMADR));
    seq.push_back(S(OP_SW, 1'b0, 1'b0, 1'b0, ST_MEMRD));
    seq.push_back(S(OP_SW, 1'b0, 1'b0, 1'b0, ST_MEMRD));
    seq.push_back(S(OP_SW, 1'b1, 1'b0, 1'b0, ST_MEMRD));
    seq.push_back(S(OP_SW, 1'b1, 1'b0, 1'b0, ST_MEMWB));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin $display("FAIL lw_stall[%0d] got=%h exp=%h", i, obs, e); failures++; end
    end
  endtask

  task automatic test_beq();
    step_t seq[$];
    logic [21:0] e;
    seq.push_back(S(OP_BEQ, 1'b1, 1'b1, 1'b0, ST_FETCH));
    seq.push_back(S(OP_BEQ, 1'b1, 1'b1, 1'b0, ST_DECODE));
    seq.push_back(S(OP_BEQ, 1'b1, 1'b1, 1'b0, ST_BRANCH));
    seq.push_back(S(OP_BEQ, 1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_BEQ, 1'b1, 1'b0, 1'b0, ST_DECODE));
    seq.push_back(S(OP_BEQ, 1'b1, 1'b0, 1'b0, ST_BRANCH));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin $display("FAIL beq[%0d] got=%h exp=%h", i, obs, e); failures++; end
    end
  endtask

  task automatic test_imm_jump();
    step_t seq[$];
    logic [21:0] e;
    seq.push_back(S(OP_ORI,  1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_ORI,  1'b1, 1'b0, 1'b0, ST_DECODE));
    seq.push_back(S(OP_ORI,  1'b1, 1'b0, 1'b0, ST_ORIEX));
    seq.push_back(S(OP_ORI,  1'b1, 1'b0, 1'b0, ST_IMMWB));
    seq.push_back(S(OP_ADDI, 1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_ADDI, 1'b1, 1'b0, 1'b0, ST_DECODE));
    seq.push_back(S(OP_ADDI, 1'b1, 1'b0, 1'b0, ST_ADDIEX));
    seq.push_back(S(OP_ADDI, 1'b1, 1'b0, 1'b0, ST_IMMWB));
    seq.push_back(S(OP_J,    1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_J,    1'b1, 1'b0, 1'b0, ST_DECODE));
    seq.push_back(S(OP_J,    1'b0, 1'b0, 1'b0, ST_JUMP));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin $display("FAIL imm_jump[%0d] got=%h exp=%h", i, obs, e); failures++; end
    end
  endtask

  task automatic test_illegal();
    step_t seq[$];
    logic [21:0] e;
    seq.push_back(S(6'b111111, 1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(6'b111111, 1'b1, 1'b0, 1'b1, ST_DECODE));
    seq.push_back(S(6'b111111, 1'b0, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(6'b111111, 1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(6'b010001, 1'b1, 1'b0, 1'b1, ST_DECODE));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin $display("FAIL illegal[%0d] got=%h exp=%h", i, obs, e); failures++; end
    end
  endtask

  task automatic test_back_to_back();
    step_t seq[$];
    logic [21:0] e;
    seq.push_back(S(OP_SW,    1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_SW,    1'b1, 1'b0, 1'b0, ST_DECODE));
    seq.push_back(S(OP_LW,    1'b1, 1'b0, 1'b0, ST_MEMADR));
    seq.push_back(S(OP_LW,    1'b1, 1'b0, 1'b0, ST_MEMWR));
    seq.push_back(S(OP_RTYPE, 1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_RTYPE, 1'b1, 1'b0, 1'b0, ST_DECODE));
    seq.push_back(S(OP_RTYPE, 1'b1, 1'b0, 1'b0, ST_EXEC));
    seq.push_back(S(OP_RTYPE, 1'b1, 1'b0, 1'b0, ST_ALUWB));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin $display("FAIL back_to_back[%0d] got=%h exp=%h", i, obs, e); failures++; end
    end
  endtask

  task automatic test_sw_reset();
    step_t seq[$];
    logic [21:0] e;
    seq.push_back(S(OP_SW, 1'b1, 1'b0, 1'b0, ST_FETCH));
    seq.push_back(S(OP_SW, 1'b1, 1'b0, 1'b0, ST_DECODE));
    seq.push_back(S(OP_SW, 1'b1, 1'b0, 1'b0, ST_MEMADR));
    seq.push_back(S(OP_SW, 1'b0, 1'b0, 1'b0, ST_MEMWR));
    seq.push_back(S(OP_SW, 1'b0, 1'b0, 1'b0, ST_MEMWR));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin $display("FAIL sw_stall[%0d] got=%h exp=%h", i, obs, e); failures++; end
    end
    #2 rst_n = 1'b0;
    #1 checks++;
    if (bus.mem_write !== 1'b0) begin $display("FAIL sw_reset_mem_write got=%b exp=0", bus.mem_write); failures++; end
    checks++;
    if (obs !== '0) begin $display("FAIL sw_reset_all got=%h exp=%h", obs, 22'h0); failures++; end
    @(negedge clk) rst_n = 1'b1;
    apply(S(OP_SW, 1'b0, 1'b0, 1'b0, ST_FETCH));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin $display("FAIL sw_restart got=%h exp=%h", obs, e); failures++; end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_imm_jump();
    test_illegal();
    test_back_to_back();
    test_sw_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
